// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order word reads, buffers up to two returned
// instructions with their addresses, and presents them to Decode with stall/redirect handling.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hazard,
    input  logic        pcWriteEnable,
    input  logic [31:0] pcWriteData,
    output logic        imemReqValid,
    output logic [31:0] imemReqAddr,
    input  logic        imemReqReady,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    output logic [31:0] PC,
    output logic [31:0] instr,
    output logic        instrValid
);

    logic [31:0] fetch_pc;
    logic [1:0]  outstanding;
    logic [1:0]  discard_count;
    logic [1:0]  occupancy;

    // Request-address tags for in-flight reads; every response consumes one, dropped or not.
    logic [31:0] tag_addr [2];
    logic        tag_rd, tag_wr;

    logic [31:0] buf_addr [2];
    logic [31:0] buf_data [2];
    logic        buf_rd, buf_wr;

    logic        pop;
    logic        push;
    logic        accept;
    logic [2:0]  pending;

    always_comb begin
        pop          = !hazard && !pcWriteEnable && (occupancy != 2'd0);
        push         = imemRespValid && !pcWriteEnable && (discard_count == 2'd0);
        pending      = {1'b0, outstanding} + {1'b0, occupancy} - {2'b00, pop};
        imemReqValid = !reset && !pcWriteEnable && (pending < 3'd2);
        imemReqAddr  = fetch_pc;
        accept       = imemReqValid && imemReqReady;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc      <= RESET_PC;
            outstanding   <= '0;
            discard_count <= '0;
            occupancy     <= '0;
            tag_rd        <= 1'b0;
            tag_wr        <= 1'b0;
            buf_rd        <= 1'b0;
            buf_wr        <= 1'b0;
            PC            <= '0;
            instr         <= NOP_INSTR;
            instrValid    <= 1'b0;
        end else begin
            outstanding <= outstanding + {1'b0, accept} - {1'b0, imemRespValid};
            if (accept)
                tag_wr <= ~tag_wr;
            if (imemRespValid)
                tag_rd <= ~tag_rd;

            if (pcWriteEnable) begin
                fetch_pc      <= {pcWriteData[31:2], 2'b00};
                discard_count <= outstanding - {1'b0, imemRespValid};
                occupancy     <= '0;
                buf_rd        <= 1'b0;
                buf_wr        <= 1'b0;
                PC            <= '0;
                instr         <= NOP_INSTR;
                instrValid    <= 1'b0;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + 32'd4;
                if (imemRespValid && (discard_count != 2'd0))
                    discard_count <= discard_count - 2'd1;
                if (push)
                    buf_wr <= ~buf_wr;
                occupancy <= occupancy + {1'b0, push} - {1'b0, pop};

                if (pop) begin
                    buf_rd     <= ~buf_rd;
                    PC         <= buf_addr[buf_rd];
                    instr      <= buf_data[buf_rd];
                    instrValid <= 1'b1;
                end else if (!hazard) begin
                    PC         <= '0;
                    instr      <= NOP_INSTR;
                    instrValid <= 1'b0;
                end
            end
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointers and counters above.
    always_ff @(posedge clk) begin
        if (accept)
            tag_addr[tag_wr] <= fetch_pc;
        if (!reset && push) begin
            buf_addr[buf_wr] <= tag_addr[tag_rd];
            buf_data[buf_wr] <= imemRespData;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a resettable 1- or 2-cycle in-order memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hazard = 1'b0;
    logic        pcWriteEnable = 1'b0;
    logic [31:0] pcWriteData = '0;
    logic        imemReqValid;
    logic [31:0] imemReqAddr;
    logic        imemReqReady = 1'b1;
    logic        imemRespValid;
    logic [31:0] imemRespData;
    logic [31:0] PC;
    logic [31:0] instr;
    logic        instrValid;

    int checks = 0;
    int errors = 0;
    int mem_lat = 1;

    logic        s1_v, s2_v;
    logic [31:0] s1_a, s2_a;

    fetch_unit dut (
        .clk(clk), .reset(reset), .hazard(hazard),
        .pcWriteEnable(pcWriteEnable), .pcWriteData(pcWriteData),
        .imemReqValid(imemReqValid), .imemReqAddr(imemReqAddr), .imemReqReady(imemReqReady),
        .imemRespValid(imemRespValid), .imemRespData(imemRespData),
        .PC(PC), .instr(instr), .instrValid(instrValid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            s1_v <= 1'b0; s2_v <= 1'b0; s1_a <= '0; s2_a <= '0;
        end else begin
            s1_v <= imemReqValid && imemReqReady;
            s1_a <= imemReqAddr;
            s2_v <= s1_v;
            s2_a <= s1_a;
        end
    end

    assign imemRespValid = (mem_lat == 2) ? s2_v : s1_v;
    assign imemRespData  = word((mem_lat == 2) ? s2_a : s1_a);

    task automatic step();
        @(negedge clk);
    endtask

    // Leaves the bench in the first cycle after reset release, inputs settled.
    task automatic restart(input int lat);
        reset = 1'b1; hazard = 1'b0; pcWriteEnable = 1'b0; imemReqReady = 1'b1; mem_lat = lat;
        step(); step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step(); #1;
        checks++; if (imemReqValid !== 1'b0) begin errors++; $display("FAIL reset_reqvalid got %b exp 0", imemReqValid); end
        checks++; if (imemReqAddr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 00000000", imemReqAddr); end
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 00000000", PC); end
        checks++; if (instr !== 32'h13) begin errors++; $display("FAIL reset_instr got %h exp 00000013", instr); end
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instrValid); end
    endtask

    task automatic test_stream();
        restart(1);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) begin step(); #1; end
            checks++; if (imemReqValid !== 1'b1 || imemReqAddr !== 32'(4 * k)) begin errors++;
                $display("FAIL stream_req c%0d got %b/%h exp 1/%h", k, imemReqValid, imemReqAddr, 32'(4 * k)); end
            checks++; if (instrValid !== (k >= 3)) begin errors++;
                $display("FAIL stream_valid c%0d got %b exp %b", k, instrValid, (k >= 3)); end
            if (k >= 3) begin
                checks++; if (PC !== 32'(4 * (k - 3)) || instr !== word(32'(4 * (k - 3)))) begin errors++;
                    $display("FAIL stream_out c%0d got %h/%h exp %h", k, PC, instr, 32'(4 * (k - 3))); end
            end
        end
    endtask

    // Continues from test_stream: cycle 5, PC=0x8 presented.
    task automatic test_hazard();
        hazard = 1'b1; #1;
        checks++; if (imemReqValid !== 1'b0) begin errors++; $display("FAIL hazard_reqdrop got %b exp 0", imemReqValid); end
        for (int k = 6; k <= 8; k++) begin
            step(); #1;
            checks++; if (PC !== 32'h8 || instr !== word(32'h8) || instrValid !== 1'b1) begin errors++;
                $display("FAIL hazard_hold c%0d got %h/%h/%b exp 00000008 valid", k, PC, instr, instrValid); end
            if (k < 8) begin
                checks++; if (imemReqValid !== 1'b0) begin errors++; $display("FAIL hazard_full c%0d got %b exp 0", k, imemReqValid); end
            end
        end
        hazard = 1'b0; #1;
        checks++; if (imemReqValid !== 1'b1 || imemReqAddr !== 32'h14) begin errors++;
            $display("FAIL hazard_resume_req got %b/%h exp 1/00000014", imemReqValid, imemReqAddr); end
        for (int k = 0; k < 4; k++) begin
            step(); #1;
            checks++; if (PC !== 32'(12 + 4 * k) || instr !== word(32'(12 + 4 * k)) || instrValid !== 1'b1) begin errors++;
                $display("FAIL hazard_resume_out %0d got %h/%b exp %h", k, PC, instrValid, 32'(12 + 4 * k)); end
        end
    endtask

    task automatic test_redirect();
        restart(2);
        step(); step();
        pcWriteEnable = 1'b1; pcWriteData = 32'h100; #1;
        checks++; if (imemReqValid !== 1'b0) begin errors++; $display("FAIL redir_noreq got %b exp 0", imemReqValid); end
        step(); pcWriteEnable = 1'b0; #1;
        checks++; if (PC !== 32'h0 || instr !== 32'h13 || instrValid !== 1'b0) begin errors++;
            $display("FAIL redir_bubble got %h/%h/%b exp 00000000/00000013/0", PC, instr, instrValid); end
        checks++; if (imemReqValid !== 1'b1 || imemReqAddr !== 32'h100) begin errors++;
            $display("FAIL redir_req got %b/%h exp 1/00000100", imemReqValid, imemReqAddr); end
        for (int k = 4; k <= 6; k++) begin
            step(); #1;
            checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL redir_drop c%0d got valid %b PC %h exp 0", k, instrValid, PC); end
        end
        for (int k = 0; k < 2; k++) begin
            step(); #1;
            checks++; if (PC !== 32'(256 + 4 * k) || instr !== word(32'(256 + 4 * k)) || instrValid !== 1'b1) begin errors++;
                $display("FAIL redir_out %0d got %h/%h/%b exp %h", k, PC, instr, instrValid, 32'(256 + 4 * k)); end
        end
    endtask

    task automatic test_redirect_hazard();
        restart(1);
        repeat (5) step();
        hazard = 1'b1; pcWriteEnable = 1'b1; pcWriteData = 32'h203; #1;
        checks++; if (imemReqValid !== 1'b0) begin errors++; $display("FAIL rh_noreq got %b exp 0", imemReqValid); end
        step(); pcWriteEnable = 1'b0; #1;
        checks++; if (PC !== 32'h0 || instr !== 32'h13 || instrValid !== 1'b0) begin errors++;
            $display("FAIL rh_bubble got %h/%h/%b exp 00000000/00000013/0", PC, instr, instrValid); end
        checks++; if (imemReqValid !== 1'b1 || imemReqAddr !== 32'h200) begin errors++;
            $display("FAIL rh_req got %b/%h exp 1/00000200", imemReqValid, imemReqAddr); end
        step(); hazard = 1'b0; #1;
        step(); #1;
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL rh_early got %b exp 0", instrValid); end
        step(); #1;
        checks++; if (PC !== 32'h200 || instr !== word(32'h200) || instrValid !== 1'b1) begin errors++;
            $display("FAIL rh_out got %h/%h/%b exp 00000200 valid", PC, instr, instrValid); end
    endtask

    task automatic test_ready_stall();
        restart(1);
        repeat (5) step();
        imemReqReady = 1'b0;
        for (int k = 5; k <= 10; k++) begin
            if (k > 5) begin step(); if (k == 10) imemReqReady = 1'b1; end
            #1;
            checks++; if (imemReqValid !== 1'b1 || imemReqAddr !== 32'h14) begin errors++;
                $display("FAIL ready_addr c%0d got %b/%h exp 1/00000014", k, imemReqValid, imemReqAddr); end
            if (k == 6 || k == 7) begin
                checks++; if (PC !== 32'(4 * (k - 3)) || instrValid !== 1'b1) begin errors++;
                    $display("FAIL ready_drain c%0d got %h/%b exp %h", k, PC, instrValid, 32'(4 * (k - 3))); end
            end
            if (k >= 8) begin
                checks++; if (instrValid !== 1'b0 || instr !== 32'h13) begin errors++;
                    $display("FAIL ready_bubble c%0d got %b/%h exp 0/00000013", k, instrValid, instr); end
            end
        end
        step(); step(); step(); #1;
        checks++; if (PC !== 32'h14 || instr !== word(32'h14) || instrValid !== 1'b1) begin errors++;
            $display("FAIL ready_resume got %h/%b exp 00000014", PC, instrValid); end
        step(); #1;
        checks++; if (PC !== 32'h18 || instrValid !== 1'b1) begin errors++;
            $display("FAIL ready_next got %h/%b exp 00000018", PC, instrValid); end
    endtask

    task automatic test_wrap();
        restart(1);
        repeat (5) step();
        pcWriteEnable = 1'b1; pcWriteData = 32'hFFFF_FFF8;
        step(); pcWriteEnable = 1'b0; #1;
        checks++; if (imemReqAddr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_addr0 got %h exp fffffff8", imemReqAddr); end
        step(); #1;
        checks++; if (imemReqAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr1 got %h exp fffffffc", imemReqAddr); end
        step(); #1;
        checks++; if (imemReqAddr !== 32'h0) begin errors++; $display("FAIL wrap_addr2 got %h exp 00000000", imemReqAddr); end
        for (int k = 0; k < 4; k++) begin
            step(); #1;
            checks++; if (PC !== 32'(32'hFFFF_FFF8 + 4 * k) || instr !== word(32'(32'hFFFF_FFF8 + 4 * k)) || instrValid !== 1'b1) begin errors++;
                $display("FAIL wrap_out %0d got %h/%b exp %h", k, PC, instrValid, 32'(32'hFFFF_FFF8 + 4 * k)); end
        end
    endtask

    task automatic test_reset_midflight();
        restart(2);
        step(); reset = 1'b1; #1;
        checks++; if (imemReqValid !== 1'b0) begin errors++; $display("FAIL mid_reqvalid got %b exp 0", imemReqValid); end
        step(); #1;
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL mid_inreset got %b exp 0", instrValid); end
        step(); reset = 1'b0; #1;
        checks++; if (imemReqValid !== 1'b1 || imemReqAddr !== 32'h0) begin errors++;
            $display("FAIL mid_first_req got %b/%h exp 1/00000000", imemReqValid, imemReqAddr); end
        for (int k = 4; k <= 6; k++) begin
            step(); #1;
            checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL mid_stale c%0d got %b PC %h exp 0", k, instrValid, PC); end
        end
        step(); #1;
        checks++; if (PC !== 32'h0 || instr !== word(32'h0) || instrValid !== 1'b1) begin errors++;
            $display("FAIL mid_first_out got %h/%h/%b exp 00000000 valid", PC, instr, instrValid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hazard();
        test_redirect();
        test_redirect_hazard();
        test_ready_stall();
        test_wrap();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, address of the first instruction fetched after reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000013 (addi x0,x0,0), instruction presented on a bubble.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 hazard  in  1  Decode stall; the Decode-facing outputs hold while it is 1.
REQ-006 pcWriteEnable  in  1  redirect request from Execute (branch/jump taken).
REQ-007 pcWriteData  in  32  redirect target address.
REQ-008 imemReqValid  out  1  instruction-memory read request valid.
REQ-009 imemReqAddr  out  32  word address of the request.
REQ-010 imemReqReady  in  1  memory accepts the request this cycle when high together with imemReqValid.
REQ-011 imemRespValid  in  1  read data valid; responses return in request order, at least 1 cycle after acceptance, with no backpressure.
REQ-012 imemRespData  in  32  returned instruction word.
REQ-013 PC  out  32  address of the instruction presented to Decode.
REQ-014 instr  out  32  instruction presented to Decode.
REQ-015 instrValid  out  1  1 = instr is a real fetched instruction; 0 = bubble.

Function
REQ-016 The fetch address register fetchPC SHALL drive imemReqAddr and SHALL advance by 4 on every accepted request.
REQ-017 The block SHALL track the outstanding-request count (0..2) and a 2-entry in-order buffer of {address, instruction} pairs.
REQ-018 The block SHALL assert imemReqValid only when (outstanding + bufferOccupancy - popThisCycle) < 2, reset=0, and pcWriteEnable=0.
REQ-019 An accepted response with discardCount=0 SHALL be written into the buffer tagged with the address of its request; the same response SHALL NOT reach the outputs in the cycle it arrives (no bypass).
REQ-020 When hazard=0 and pcWriteEnable=0, the outputs SHALL load from the buffer head (instrValid=1, entry popped) if the buffer is non-empty, otherwise PC=0, instr=NOP_INSTR, instrValid=0.
REQ-021 When hazard=1 and pcWriteEnable=0, PC/instr/instrValid SHALL hold and no entry SHALL be popped; requests continue until capacity is reached.
REQ-022 When pcWriteEnable=1 (regardless of hazard): fetchPC <= {pcWriteData[31:2],2'b00}; buffer cleared; outputs become a bubble (PC=0, instr=NOP_INSTR, instrValid=0); discardCount <= outstanding - (imemRespValid ? 1 : 0).
REQ-023 A response arriving in the redirect cycle, or while discardCount>0, SHALL be dropped; each drop while discardCount>0 SHALL decrement discardCount.
REQ-024 New-stream requests MAY issue while discardCount>0, subject to REQ-018 with outstanding including undiscarded old requests.
REQ-025 Simultaneous accepted request and arriving response in one cycle SHALL leave outstanding unchanged; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-026 fetchPC SHALL wrap from 32'hFFFFFFFC to 32'h00000000 without error.
REQ-027 With a 1-cycle memory, hazard=0 and no redirect, the block SHALL sustain one valid instruction per cycle after a 3-cycle start-up latency from reset release.

Reset
REQ-028 While reset=1: fetchPC=RESET_PC, outstanding=0, discardCount=0, buffer empty, imemReqValid=0, PC=0, instr=NOP_INSTR, instrValid=0.
REQ-029 Reset asserted mid-operation SHALL abandon all in-flight requests; responses arriving in the reset cycle SHALL be ignored, and the memory is likewise reset, so no stale data returns afterwards.
REQ-030 The first request (imemReqAddr=RESET_PC) SHALL issue in the first cycle after reset deasserts.

Verification
REQ-031 Reset release, 1-cycle memory, hazard=0 -> requests 0x0,0x4,0x8... on consecutive cycles; instrValid rises 3 cycles after release; then PC=0x0,0x4,0x8 on consecutive cycles.
REQ-032 hazard=1 for 3 cycles while PC=0x8 -> PC/instr hold at 0x8 for 3 cycles, imemReqValid drops once outstanding+occupancy=2, streaming resumes at 0x0C with no gap or duplicate.
REQ-033 pcWriteEnable=1, pcWriteData=0x100, with 2 requests outstanding -> next cycle bubble, the 2 old responses are dropped, first valid output PC=0x100.
REQ-034 Redirect to 0x203 with hazard=1 in the same cycle -> bubble presented, first request address 0x200.
REQ-035 imemReqReady=0 for 5 cycles -> imemReqAddr stable at the same value, bubbles presented once the buffer drains, no address skipped when ready returns.
REQ-036 reset asserted with 1 response outstanding -> no stale instruction is presented; after release the first valid PC=RESET_PC.
